// File: rtl/uart_pkg.sv
// Shared UART definitions: divisor config type, minimum divisor and the
// reset-divisor calculation used by the baud generator and tx/rx engines.
package uart_pkg;

    localparam int CFG_INT_W  = 32;
    localparam int CFG_FRAC_W = 16;
    localparam int MIN_DIV    = 2;

    typedef struct packed {
        logic [CFG_INT_W-1:0]  div_int;
        logic [CFG_FRAC_W-1:0] div_frac;
    } baud_cfg_t;

    // Clocks per oversample tick in fixed point, rounded to nearest.
    function automatic baud_cfg_t default_div(input longint clock_input, input longint baudrate,
                                              input longint oversampling, input int frac_bits);
        longint    den;
        longint    q;
        baud_cfg_t c;
        den        = baudrate * oversampling;
        q          = ((clock_input << frac_bits) + den / 2) / den;
        c.div_int  = CFG_INT_W'(q >> frac_bits);
        c.div_frac = CFG_FRAC_W'(q & ((longint'(1) << frac_bits) - 1));
        return c;
    endfunction

endpackage

// File: rtl/frac_prescaler.sv
// Fractional prescaler: counts P = div_int + carry clocks per oversample tick,
// where carry comes from a phase accumulator advanced by div_frac each tick.
module frac_prescaler #(
    parameter int DIV_WIDTH = 16,
    parameter int FRAC_BITS = 4
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    output logic                 os_tick,
    output logic                 period_end
);

    logic [DIV_WIDTH:0] pcnt;
    logic [DIV_WIDTH:0] period;
    logic [FRAC_BITS-1:0] acc;
    logic [FRAC_BITS:0]   acc_sum;
    logic                 carry;

    assign period     = {1'b0, div_int} + (DIV_WIDTH+1)'(carry);
    assign period_end = !restart && (pcnt == period - (DIV_WIDTH+1)'(1));
    assign acc_sum    = {1'b0, acc} + {1'b0, div_frac};

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pcnt    <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            os_tick <= 1'b0;
        end else if (restart) begin
            pcnt    <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            os_tick <= 1'b0;
        end else begin
            os_tick <= period_end;
            if (period_end) begin
                pcnt  <= '0;
                acc   <= acc_sum[FRAC_BITS-1:0];
                carry <= acc_sum[FRAC_BITS];
            end else begin
                pcnt  <= pcnt + (DIV_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud/oversample strobe generator with shadowed fractional divisor,
// oversample index and bit/mid-bit strobes, realignable by sync.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLOCK_INPUT  = 50_000_000,
    parameter int BAUDRATE     = 9600,
    parameter int OVERSAMPLING = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_BITS    = 4
) (
    input  logic                            clock,
    input  logic                            nreset,
    input  logic                            en,
    input  logic                            sync,
    input  logic                            cfg_load,
    input  logic [DIV_WIDTH-1:0]            div_int,
    input  logic [FRAC_BITS-1:0]            div_frac,
    output logic                            os_tick,
    output logic                            bit_tick,
    output logic                            mid_tick,
    output logic [$clog2(OVERSAMPLING)-1:0] os_count,
    output logic                            cfg_err
);

    localparam int OS_W = $clog2(OVERSAMPLING);
    localparam baud_cfg_t DEF_CFG = default_div(longint'(CLOCK_INPUT), longint'(BAUDRATE),
                                                longint'(OVERSAMPLING), FRAC_BITS);
    localparam logic [DIV_WIDTH-1:0] DEF_INT  = DEF_CFG.div_int[DIV_WIDTH-1:0];
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = DEF_CFG.div_frac[FRAC_BITS-1:0];
    localparam logic [DIV_WIDTH-1:0] MIN_INT  = DIV_WIDTH'(MIN_DIV);

    logic [DIV_WIDTH-1:0] shd_int, act_int, nxt_int, eff_int;
    logic [FRAC_BITS-1:0] shd_frac, act_frac, nxt_frac;
    logic                 restart, period_end, apply;

    // A load in the same cycle as an apply point wins over the older shadow.
    assign nxt_int  = cfg_load ? div_int  : shd_int;
    assign nxt_frac = cfg_load ? div_frac : shd_frac;
    assign restart  = !en || sync;
    assign apply    = restart || period_end;
    assign eff_int  = (act_int < MIN_INT) ? MIN_INT : act_int;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            shd_int  <= DEF_INT;
            shd_frac <= DEF_FRAC;
            act_int  <= DEF_INT;
            act_frac <= DEF_FRAC;
            cfg_err  <= 1'b0;
        end else begin
            if (cfg_load) begin
                shd_int  <= div_int;
                shd_frac <= div_frac;
            end
            if (apply) begin
                act_int  <= nxt_int;
                act_frac <= nxt_frac;
            end
            cfg_err <= en && ((apply ? nxt_int : act_int) < MIN_INT);
        end
    end

    frac_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_presc (
        .clock      (clock),
        .nreset     (nreset),
        .restart    (restart),
        .div_int    (eff_int),
        .div_frac   (act_frac),
        .os_tick    (os_tick),
        .period_end (period_end)
    );

    // Strobes are registered alongside os_tick so they coincide with it.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            os_count <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else if (restart) begin
            os_count <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            bit_tick <= period_end && (os_count == OS_W'(OVERSAMPLING - 1));
            mid_tick <= period_end && (os_count == OS_W'(OVERSAMPLING/2 - 1));
            if (period_end)
                os_count <= os_count + OS_W'(1);
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: periods, strobes, shadow reload, sync,
// clamping, en and reset behaviour against hand-computed edge counts.
module tb_baud_tick_gen;

    logic        clock = 1'b0;
    logic        nreset;
    logic        en, sync, cfg_load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        os_tick, bit_tick, mid_tick, cfg_err;
    logic [3:0]  os_count;

    int checks   = 0;
    int failures = 0;
    int misal    = 0;
    int n;
    int os_q[$], bit_q[$], mid_q[$];

    baud_tick_gen #(
        .CLOCK_INPUT  (50_000_000),
        .BAUDRATE     (9600),
        .OVERSAMPLING (16),
        .DIV_WIDTH    (16),
        .FRAC_BITS    (4)
    ) dut (
        .clock    (clock),
        .nreset   (nreset),
        .en       (en),
        .sync     (sync),
        .cfg_load (cfg_load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .os_count (os_count),
        .cfg_err  (cfg_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    // Edges until the next os_tick is seen; -1 if none within the budget.
    task automatic wait_os(output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!os_tick && cnt < 1000);
        if (!os_tick) cnt = -1;
    endtask

    task automatic run_log(input int ncyc);
        os_q.delete();
        bit_q.delete();
        mid_q.delete();
        for (int e = 1; e <= ncyc; e++) begin
            step(1);
            if (os_tick)  os_q.push_back(e);
            if (bit_tick) bit_q.push_back(e);
            if (mid_tick) mid_q.push_back(e);
            if ((bit_tick || mid_tick) && !os_tick) misal++;
        end
    endtask

    task automatic load_idle(input logic [15:0] di, input logic [3:0] df);
        en = 1'b0; cfg_load = 1'b1; div_int = di; div_frac = df;
        step(1);
        cfg_load = 1'b0; en = 1'b1;
    endtask

    initial begin
        nreset = 1'b0; en = 1'b0; sync = 1'b0; cfg_load = 1'b0;
        div_int = '0; div_frac = '0;
        #1;
        chk("rst_os_tick",  32'(os_tick),  0);
        chk("rst_bit_mid",  32'({bit_tick, mid_tick}), 0);
        chk("rst_os_count", 32'(os_count), 0);
        chk("rst_cfg_err",  32'(cfg_err),  0);
        #22 nreset = 1'b1;
        step(2);

        // Integer divisor 4: tick every 4, bit every 64, mid 32 after bit
        load_idle(16'd4, 4'd0);
        run_log(130);
        chk("a_first_os", 32'(os_q.size() > 0 ? os_q[0] : -1), 4);
        chk("a_os_count", 32'(os_q.size()), 32);
        chk("a_os_span",  32'(os_q.size() == 32 ? os_q[31] - os_q[0] : -1), 124);
        chk("a_bit0",     32'(bit_q.size() > 0 ? bit_q[0] : -1), 64);
        chk("a_bit_gap",  32'(bit_q.size() > 1 ? bit_q[1] - bit_q[0] : -1), 64);
        chk("a_mid0",     32'(mid_q.size() > 0 ? mid_q[0] : -1), 32);
        chk("a_mid_after_bit", 32'(mid_q.size() > 1 && bit_q.size() > 0 ? mid_q[1] - bit_q[0] : -1), 32);

        // Divisor 4 + 8/16: periods 4,4,5,4,5... and 144 clocks per 32 ticks
        load_idle(16'd4, 4'd8);
        run_log(160);
        chk("b_p1",   32'(os_q.size() > 3 ? os_q[1] - os_q[0] : -1), 4);
        chk("b_p2",   32'(os_q.size() > 3 ? os_q[2] - os_q[1] : -1), 5);
        chk("b_p3",   32'(os_q.size() > 3 ? os_q[3] - os_q[2] : -1), 4);
        chk("b_span32", 32'(os_q.size() > 32 ? os_q[32] - os_q[0] : -1), 144);
        chk("strobe_align", 32'(misal), 0);

        // Mid-period reload to 6: current period stays 4
        load_idle(16'd4, 4'd0);
        wait_os(n); chk("c_first", 32'(n), 4);
        step(1);
        cfg_load = 1'b1; div_int = 16'd6;
        step(1);
        cfg_load = 1'b0;
        wait_os(n); chk("c_cur_period", 32'(n), 2);
        wait_os(n); chk("c_new_p1", 32'(n), 6);
        wait_os(n); chk("c_new_p2", 32'(n), 6);
        chk("c_os_count", 32'(os_count), 4);

        // Sync at os_count 9 realigns without a strobe
        repeat (5) wait_os(n);
        chk("d_os_count9", 32'(os_count), 9);
        step(2);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("d_sync_count", 32'(os_count), 0);
        chk("d_sync_ticks", 32'({os_tick, bit_tick, mid_tick}), 0);
        wait_os(n); chk("d_after_sync", 32'(n), 6);
        chk("d_count1", 32'(os_count), 1);
        chk("d_no_bit", 32'(bit_tick), 0);

        // Clamp: div 1 behaves as 2 and flags cfg_err until div 3 lands
        cfg_load = 1'b1; div_int = 16'd1;
        step(1);
        cfg_load = 1'b0;
        chk("e_err_pending", 32'(cfg_err), 0);
        wait_os(n); chk("e_rest", 32'(n), 5);
        chk("e_err_set", 32'(cfg_err), 1);
        wait_os(n); chk("e_clamp_p1", 32'(n), 2);
        wait_os(n); chk("e_clamp_p2", 32'(n), 2);
        cfg_load = 1'b1; div_int = 16'd3;
        step(1);
        cfg_load = 1'b0;
        chk("e_err_hold", 32'(cfg_err), 1);
        step(1);
        chk("e_err_clear", 32'(cfg_err), 0);
        chk("e_bound_tick", 32'(os_tick), 1);
        wait_os(n); chk("e_p3", 32'(n), 3);

        // en low clears within one cycle
        step(1);
        en = 1'b0;
        step(1);
        chk("f_en_ticks", 32'({os_tick, bit_tick, mid_tick}), 0);
        chk("f_en_count", 32'(os_count), 0);

        // Reset mid-bit with a pending shadow: back to 325 + 8/16
        en = 1'b1;
        step(10);
        cfg_load = 1'b1; div_int = 16'd7;
        step(1);
        cfg_load = 1'b0;
        chk("f_pre_rst_count", 32'(os_count), 3);
        nreset = 1'b0;
        #1;
        chk("f_rst_count", 32'(os_count), 0);
        chk("f_rst_outs", 32'({os_tick, bit_tick, mid_tick, cfg_err}), 0);
        #2 nreset = 1'b1;
        wait_os(n); chk("g_def_p1", 32'(n), 325);
        wait_os(n); chk("g_def_p2", 32'(n), 325);
        wait_os(n); chk("g_def_p3", 32'(n), 326);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Next-generation UART baud/oversampling timing generator with a runtime-programmable fractional divisor.
- Produces single-cycle oversample, bit and mid-bit strobes for the tx and rx engines in place of a divided output clock, so it is fully synchronous to `clock`.
- Adds an rx phase-realign input for start-bit alignment.
- Adds shadowed divisor reload at period boundaries.

Parameters:
- CLOCK_INPUT, 50_000_000, system clock frequency in Hz.
- BAUDRATE, 9600, baud rate used to compute the reset divisor.
- OVERSAMPLING, 16, oversample ticks per bit; power of two, 4..32.
- DIV_WIDTH, 16, width of the integer divisor.
- FRAC_BITS, 4, width of the fractional divisor and accumulator.

Ports:
- clock  in  1  system clock
- nreset  in  1  asynchronous, active-low reset
- en  in  1  generator enable; low clears all counters
- sync  in  1  phase restart pulse (rx start-bit edge)
- cfg_load  in  1  capture div_int/div_frac into shadow
- div_int  in  DIV_WIDTH  integer clocks per oversample tick
- div_frac  in  FRAC_BITS  fractional part, units of 1/2^FRAC_BITS clock
- os_tick  out  1  one-cycle oversample strobe
- bit_tick  out  1  one-cycle strobe at bit boundary
- mid_tick  out  1  one-cycle strobe at bit centre
- os_count  out  $clog2(OVERSAMPLING)  current oversample index
- cfg_err  out  1  high while active div_int < 2 (clamped)

Behaviour:
- Reset (nreset low, asynchronous):
  - pcnt, acc, os_count = 0; all tick outputs 0; cfg_err 0.
  - Active and shadow divisor = DEFAULT_DIV from package function: CLOCK_INPUT*2^FRAC_BITS/(BAUDRATE*OVERSAMPLING), rounded to nearest, split into int and frac parts.
- Oversample period P:
  - P = div_int + carry, where carry is the carry-out of acc + div_frac evaluated at the previous os_tick. acc keeps the low FRAC_BITS bits.
  - Active div_int values 0 or 1 are clamped to 2; cfg_err is high while clamped.
- Prescaler pcnt counts 0..P-1:
  - Registered os_tick is high for exactly one cycle, in the cycle after pcnt reaches P-1.
  - First os_tick is P clocks after the first clock edge with en high; thereafter every P clocks.
- os_count:
  - Increments on every os_tick and wraps OVERSAMPLING-1 -> 0.
  - bit_tick coincides with the os_tick that wraps os_count to 0.
  - mid_tick coincides with the os_tick that sets os_count to OVERSAMPLING/2.
- cfg_load:
  - Captures the inputs into shadow in the same cycle.
  - Shadow is copied to active at the next oversample period boundary (pcnt restart).
  - If en is low, the copy happens on the next clock.
  - A new cfg_load overwrites a pending shadow value; the last load wins.
- sync (with en high) has priority over the terminal count:
  - Next cycle: pcnt = 0, acc = 0, os_count = 0.
  - No os_tick, bit_tick or mid_tick is generated from the cleared count.
  - A pending shadow is applied.
  - Next os_tick is P clocks later.
- sync together with cfg_load: the new values become active immediately.
- en low: counters are held at 0 and outputs are 0 within one cycle; the shadow is kept.
- A reset mid-operation discards the shadow and returns the divisor to DEFAULT_DIV.
- No combinational path from any input to any output.

Decomposition:
- Package uart_pkg (shared with tx/rx):
  - function default_div(CLOCK_INPUT, BAUDRATE, OVERSAMPLING, FRAC_BITS) returning a packed {int, frac} struct.
  - typedef baud_cfg_t {div_int, div_frac}.
  - constant MIN_DIV = 2.
- Sub-module frac_prescaler:
  - Contains pcnt, acc, period computation and os_tick generation.
  - Inputs: restart and active cfg.
- Top level holds the shadow register, os_count, bit/mid decode and cfg_err.

Test Plan:
- cfg div_int=4, frac=0, OVERSAMPLING=16, en rises -> os_tick every 4 clocks; bit_tick every 64 clocks; mid_tick 32 clocks after each bit_tick.
- div_int=4, frac=8 (FRAC_BITS=4) -> os_tick periods alternate 4,5; average 4.5 over 32 ticks; 144 clocks per 32 ticks exactly.
- Mid-period cfg_load div_int=6 while running at div_int=4 -> current period stays 4; next periods are 6; no extra or missing os_tick.
- sync pulse when os_count=9 -> os_count=0 next cycle; next os_tick P clocks after sync; no bit_tick emitted at the realign.
- cfg_load div_int=1 -> cfg_err=1 after activation; os_tick period = 2; load div_int=3 -> cfg_err clears at the boundary.
- nreset asserted mid-bit and en toggled low -> all outputs 0 immediately (reset) or within one cycle (en); after release, timing restarts from DEFAULT_DIV (50 MHz/9600/16 -> int 325, frac 8).
